adxl345_spi_responder: RTL
==========================

# adxl345_spi_responder

Synthesizable SPI-target model of the ADXL345 register interface: the far end of the SPI link that the accelerometer driver initiates against. Decodes 16-bit (or multi-byte) mode-3 frames on discrete pins, serves a 64×8 register file, and refreshes the DATAX0..DATAZ1 registers from an AXI-Stream sample source. Used for on-board loopback bring-up and as the DUT partner in driver testbenches.

## Interface
- `SCLK_SYNC_STAGES`, 2: synchronizer depth on sclk, cs_n and mosi.
- `DEVID_VALUE`, 8'hE5: read-only contents of register 0x00.
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- sclk  input  1  SPI clock from initiator, asynchronous, CPOL=1.
- cs_n  input  1  active-low chip select, asynchronous.
- mosi  input  1  serial data in, asynchronous.
- miso  output  1  serial data out; 0 whenever miso_oe=0.
- miso_oe  output  1  1 while selected and in a read data phase.
- sample_stream  axis_interface.Sink  DATA_WIDTH=48  {Z,Y,X} 16-bit samples, X in [15:0].
- measure_enable  output  1  POWER_CTL[3].
- data_format  output  8  DATA_FORMAT (0x31) contents.
- frame_error  output  1  one-cycle pulse when cs_n rises mid-byte.

## Operation
- Frame: header byte MSB-first = {R/W (1=read), MB, addr[5:0]}, then data bytes. Sample mosi on sclk rising edge; shift miso on sclk falling edge (CPHA=1).
- FSM states: WAIT_CS_HIGH (entered from reset; leaves on synchronized cs_n=1), IDLE, HEADER, DATA.
  - IDLE -> HEADER on cs_n falling; bit_count=0.
  - HEADER: shift 8 bits; on 8th rising edge latch rw, mb, addr; if read, load reg[addr] into tx shifter -> DATA.
  - DATA read: bit 7 driven after 1st falling edge, miso_oe=1. After 8th rising edge: if mb, addr<=addr+1 (6-bit wrap 0x3F->0x00) and reload; else subsequent bytes return 0 and miso_oe=0.
  - DATA write: after 8th rising edge, write byte to reg[addr] if writable; if mb, addr+1 and continue, else ignore later bytes.
  - Any state except WAIT_CS_HIGH -> IDLE on cs_n rising. Partial byte discarded, no write; frame_error pulses if bit_count≠0.
- Writable: 0x1D–0x2F, 0x31, 0x38. Writes to any other address are dropped silently.
- Reset values: 0x00=DEVID_VALUE, 0x2C=8'h0A, all others 0.
- INT_SOURCE (0x30) bit7 DATA_READY: set on sample load; cleared when a read frame returns any of 0x32–0x37.
- sample_stream.tready=1 only in IDLE with cs_n synchronized high. On handshake: if measure_enable, 0x32..0x37 <= tdata bytes [7:0]..[47:40] in one cycle and set DATA_READY; else discard. Guarantees no tearing inside a multi-byte read.

## Timing
- Pin-to-decision latency: SCLK_SYNC_STAGES + 1 clk (edge detect). Requirement on initiator: sclk half-period ≥ SCLK_SYNC_STAGES+2 clk; cs_n setup to first falling sclk edge ≥ same.
- miso updates SCLK_SYNC_STAGES+1 clk after the sclk falling pin edge; valid well before the next rising edge under the above requirement.
- Register write commits 1 clk after the 8th detected rising edge of a data byte; read-back in the same frame (MB) sees the new value.
- Reset outputs: miso=0, miso_oe=0, sample_stream.tready=0, measure_enable=0, data_format=0, frame_error=0. Reset mid-frame: full register reinit, remainder of frame ignored via WAIT_CS_HIGH.
- Simultaneous cs_n rise and sample valid: cs edge processed first; tready asserts the following cycle.

## Structure
- `adxl345_pkg`: register address constants, reset-value function, writable mask, R/W and MB bit positions, state typedef. Shared with the driver so both ends agree on the register map.
- Sub-module `spi_pin_sync`: synchronizers for sclk/cs_n/mosi plus rising/falling edge pulses and synchronized levels.

## Test plan
- Read 0x00 (frame 16'h8000) -> MISO byte 0xE5; miso_oe high for exactly the 8 data bits.
- Write 0x2D=0x08 then 0x31=0x0B -> measure_enable=1, data_format=8'h0B; write to 0x00 -> DEVID read still 0xE5.
- measure on, push tdata 48'h0003_0002_0001; MB read from 0x32, 6 bytes -> 01 00 02 00 03 00; INT_SOURCE[7] 1 before, 0 after.
- MB read starting 0x3F, 2 bytes -> reg 0x3F then reg 0x00 (0xE5).
- Raise cs_n after 12 bits of write 0x1E -> frame_error pulse, 0x1E unchanged; next full frame decodes correctly.
- Assert reset after 5 header bits, cs_n held low, then complete frame -> no response; after cs_n high/low, normal read of 0x2C returns 0x0A.

Source files
------------

// File: rtl/adxl345_pkg.sv
// ADXL345 register map shared by the SPI responder and the driver.
// Addresses, header bit positions, reset values, writability and FSM encodings.
package adxl345_pkg;

    localparam logic [5:0] REG_DEVID       = 6'h00;
    localparam logic [5:0] REG_BW_RATE     = 6'h2C;
    localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
    localparam logic [5:0] REG_INT_SOURCE  = 6'h30;
    localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
    localparam logic [5:0] REG_DATAX0      = 6'h32;
    localparam logic [5:0] REG_DATAZ1      = 6'h37;
    localparam logic [5:0] REG_FIFO_CTL    = 6'h38;

    localparam int HDR_RW_BIT            = 7;
    localparam int HDR_MB_BIT            = 6;
    localparam int POWER_CTL_MEASURE_BIT = 3;
    localparam int INT_DATA_READY_BIT    = 7;

    // One bit per address: 0x1D..0x2F, 0x31 and 0x38 accept writes.
    localparam logic [63:0] WRITABLE_MASK = 64'h0102_FFFF_E000_0000;

    typedef logic [1:0] state_t;
    localparam state_t ST_WAIT_CS_HIGH = 2'd0;
    localparam state_t ST_IDLE         = 2'd1;
    localparam state_t ST_HEADER       = 2'd2;
    localparam state_t ST_DATA         = 2'd3;

    function automatic logic is_writable(input logic [5:0] addr);
        return WRITABLE_MASK[addr];
    endfunction

    function automatic logic is_sample_reg(input logic [5:0] addr);
        return (addr >= REG_DATAX0) && (addr <= REG_DATAZ1);
    endfunction

    function automatic logic [7:0] reset_value(input logic [5:0] addr, input logic [7:0] devid);
        if (addr == REG_DEVID)   return devid;
        if (addr == REG_BW_RATE) return 8'h0A;
        return 8'h00;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizes the asynchronous SPI pins into clk and derives edge pulses.
// Edge pulses and synchronized levels share the same latency so mosi lines up with sclk_rise.
module spi_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_rise,
    output logic cs_fall,
    output logic cs_n_s,
    output logic mosi_s
);

    logic [STAGES-1:0] sclk_q, cs_q, mosi_q;
    logic              sclk_prev, cs_prev;

    // cs_n resets to "selected" so the FSM only leaves WAIT_CS_HIGH once the pin is really high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_q    <= '1;
            cs_q      <= '0;
            mosi_q    <= '0;
            sclk_prev <= 1'b1;
            cs_prev   <= 1'b0;
        end else begin
            sclk_q[0] <= sclk;
            cs_q[0]   <= cs_n;
            mosi_q[0] <= mosi;
            for (int i = 1; i < STAGES; i++) begin
                sclk_q[i] <= sclk_q[i-1];
                cs_q[i]   <= cs_q[i-1];
                mosi_q[i] <= mosi_q[i-1];
            end
            sclk_prev <= sclk_q[STAGES-1];
            cs_prev   <= cs_q[STAGES-1];
        end
    end

    assign sclk_rise = sclk_q[STAGES-1] & ~sclk_prev;
    assign sclk_fall = ~sclk_q[STAGES-1] & sclk_prev;
    assign cs_rise   = cs_q[STAGES-1] & ~cs_prev;
    assign cs_fall   = ~cs_q[STAGES-1] & cs_prev;
    assign cs_n_s    = cs_q[STAGES-1];
    assign mosi_s    = mosi_q[STAGES-1];

endmodule

// File: rtl/adxl345_spi_responder.sv
// SPI mode-3 target model of the ADXL345 register file with an AXI-Stream sample port.
// Samples only load in IDLE with cs_n high, so a multi-byte read never sees a torn sample.
module adxl345_spi_responder
    import adxl345_pkg::*;
#(
    parameter int         SCLK_SYNC_STAGES = 2,
    parameter logic [7:0] DEVID_VALUE      = 8'hE5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic        sample_stream_tvalid,
    output logic        sample_stream_tready,
    input  logic [47:0] sample_stream_tdata,
    output logic        measure_enable,
    output logic [7:0]  data_format,
    output logic        frame_error
);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, cs_n_s, mosi_s;

    spi_pin_sync #(.STAGES(SCLK_SYNC_STAGES)) u_pin_sync (
        .clk       (clk),
        .reset     (reset),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_rise   (cs_rise),
        .cs_fall   (cs_fall),
        .cs_n_s    (cs_n_s),
        .mosi_s    (mosi_s)
    );

    state_t      state;
    logic [7:0]  regs [64];
    logic [2:0]  bit_count;
    logic [6:0]  shift_in;
    logic [7:0]  tx_shift;
    logic [7:0]  rx_byte;
    logic [5:0]  addr;
    logic        rw, mb, active, miso_bit;

    assign rx_byte              = {shift_in, mosi_s};
    assign sample_stream_tready = (state == ST_IDLE) && cs_n_s;
    assign measure_enable       = regs[REG_POWER_CTL][POWER_CTL_MEASURE_BIT];
    assign data_format          = regs[REG_DATA_FORMAT];
    assign miso                 = miso_oe & miso_bit;

    always_ff @(posedge clk) begin
        frame_error <= 1'b0;
        if (reset) begin
            state     <= ST_WAIT_CS_HIGH;
            bit_count <= '0;
            shift_in  <= '0;
            tx_shift  <= '0;
            addr      <= '0;
            rw        <= 1'b0;
            mb        <= 1'b0;
            active    <= 1'b0;
            miso_bit  <= 1'b0;
            miso_oe   <= 1'b0;
            for (int i = 0; i < 64; i++) regs[i] <= reset_value(6'(i), DEVID_VALUE);
        end else begin
            case (state)
                ST_WAIT_CS_HIGH: if (cs_n_s) state <= ST_IDLE;
                ST_IDLE: begin
                    if (cs_fall) begin
                        state     <= ST_HEADER;
                        bit_count <= '0;
                    end
                    if (sample_stream_tready && sample_stream_tvalid && measure_enable) begin
                        for (int i = 0; i < 6; i++)
                            regs[REG_DATAX0 + 6'(i)] <= sample_stream_tdata[8*i +: 8];
                        regs[REG_INT_SOURCE][INT_DATA_READY_BIT] <= 1'b1;
                    end
                end
                ST_HEADER, ST_DATA: begin
                    if (cs_rise) begin
                        // Partial byte is dropped; only a clean byte boundary ends a frame quietly.
                        state       <= ST_IDLE;
                        frame_error <= (bit_count != 3'd0);
                        active      <= 1'b0;
                        miso_oe     <= 1'b0;
                    end else if (sclk_rise) begin
                        shift_in  <= rx_byte[6:0];
                        bit_count <= bit_count + 3'd1;
                        if (bit_count == 3'd7) begin
                            if (state == ST_HEADER) begin
                                state    <= ST_DATA;
                                rw       <= rx_byte[HDR_RW_BIT];
                                mb       <= rx_byte[HDR_MB_BIT];
                                addr     <= rx_byte[5:0];
                                active   <= 1'b1;
                                tx_shift <= regs[rx_byte[5:0]];
                            end else if (active) begin
                                if (!rw && is_writable(addr)) regs[addr] <= rx_byte;
                                if (mb) begin
                                    addr     <= addr + 6'd1;
                                    tx_shift <= regs[addr + 6'd1];
                                end else begin
                                    active  <= 1'b0;
                                    miso_oe <= 1'b0;
                                end
                            end
                        end
                    end else if (sclk_fall && state == ST_DATA && rw && active) begin
                        miso_bit <= tx_shift[7];
                        tx_shift <= {tx_shift[6:0], 1'b0};
                        miso_oe  <= 1'b1;
                        // DATA_READY clears as soon as a sample byte starts going out.
                        if (bit_count == 3'd0 && is_sample_reg(addr))
                            regs[REG_INT_SOURCE][INT_DATA_READY_BIT] <= 1'b0;
                    end
                end
                default: state <= ST_WAIT_CS_HIGH;
            endcase
        end
    end

endmodule
